// File: rtl/fc1_ofm_handoff_if.sv
// FC1 -> FC2 handoff bus: FC1 write stream, FC2 start/idle handshake, FC2 read port and status.
// The master drives the stream and FC2 side inputs; the slave is the handoff buffer.
interface fc1_ofm_handoff_if #(
   parameter int DATA_WIDTH = 32,
   parameter int SEL_BITS   = 7
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  end_from_next;
   logic                  start_to_next;
   logic [SEL_BITS-1:0]   sel_ifm;
   logic [DATA_WIDTH-1:0] ifm_data_out;
   logic [SEL_BITS-1:0]   fill_count;
   logic                  frame_done;

   modport master (
      output in_valid, in_data, end_from_next, sel_ifm,
      input  in_ready, start_to_next, ifm_data_out, fill_count, frame_done
   );

   modport slave (
      input  in_valid, in_data, end_from_next, sel_ifm,
      output in_ready, start_to_next, ifm_data_out, fill_count, frame_done
   );
endinterface

// File: rtl/fc1_ofm_handoff.sv
// Collects OFM_DEPTH FC1 results, launches FC2 with a start pulse two cycles after the last word and holds the buffer until FC2 is idle again.
// Reads are combinational; in_ready is high only while filling, so the stream stalls from the last word until frame_done.
module fc1_ofm_handoff #(
   parameter int DATA_WIDTH = 32,
   parameter int OFM_DEPTH  = 84,
   parameter int SEL_BITS   = $clog2(OFM_DEPTH)
) (
   input logic               clk,
   input logic               reset,
   fc1_ofm_handoff_if.slave  bus
);
   typedef enum logic [2:0] {
      FILL,
      WAIT_NEXT,
      LAUNCH,
      BUSY,
      RELEASE
   } state_t;

   localparam logic [SEL_BITS-1:0] LAST_IDX = SEL_BITS'(OFM_DEPTH - 1);

   state_t                state_q, state_d;
   logic [SEL_BITS-1:0]   fill_count_q, fill_count_d;
   logic [DATA_WIDTH-1:0] mem_q [OFM_DEPTH];
   logic                  wr_en;

   always_comb begin
      state_d           = state_q;
      fill_count_d      = fill_count_q;
      wr_en             = 1'b0;
      bus.in_ready      = 1'b0;
      bus.start_to_next = 1'b0;
      bus.frame_done    = 1'b0;
      case (state_q)
         FILL: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               wr_en = 1'b1;
               // The count parks on the last index so FC2 sees a full frame as OFM_DEPTH-1.
               if (fill_count_q == LAST_IDX) state_d = WAIT_NEXT;
               else                          fill_count_d = fill_count_q + SEL_BITS'(1);
            end
         end
         WAIT_NEXT: begin
            if (bus.end_from_next) state_d = LAUNCH;
         end
         LAUNCH: begin
            bus.start_to_next = 1'b1;
            state_d           = BUSY;
         end
         BUSY: begin
            if (!bus.end_from_next) state_d = RELEASE;
         end
         RELEASE: begin
            if (bus.end_from_next) begin
               bus.frame_done = 1'b1;
               fill_count_d   = '0;
               state_d        = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= FILL;
         fill_count_q <= '0;
      end else begin
         state_q      <= state_d;
         fill_count_q <= fill_count_d;
      end
   end

   // Writes happen only in FILL, which keeps the buffer frozen for FC2's whole read window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < OFM_DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[fill_count_q] <= bus.in_data;
      end
   end

   always_comb begin
      bus.ifm_data_out = '0;
      if (bus.sel_ifm <= LAST_IDX) bus.ifm_data_out = mem_q[bus.sel_ifm];
   end

   assign bus.fill_count = fill_count_q;
endmodule

// File: tb/tb_fc1_ofm_handoff.sv
// Directed bench for the FC1 -> FC2 handoff buffer: fill, launch, hold, release, reset abort and read range.
module tb_fc1_ofm_handoff;
   logic clk;
   logic reset;
   int   tests;
   int   fails;

   fc1_ofm_handoff_if #(.DATA_WIDTH(32), .SEL_BITS(7)) bus ();

   fc1_ofm_handoff #(.DATA_WIDTH(32), .OFM_DEPTH(84), .SEL_BITS(7)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input int idx, input logic [31:0] exp);
      bus.sel_ifm = 7'(idx);
      #1;
      chk(tag, bus.ifm_data_out, exp);
   endtask

   initial begin
      tests             = 0;
      fails             = 0;
      reset             = 1'b1;
      bus.in_valid      = 1'b0;
      bus.in_data       = '0;
      bus.end_from_next = 1'b1;
      bus.sel_ifm       = '0;

      // reset state
      #12;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_fill_count", bus.fill_count, 0);
      chk("rst_start", bus.start_to_next, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      rd("rst_read0", 0, 0);
      tick();
      reset = 1'b0;
      tick();

      // stream 1..84 back to back with FC2 idle
      for (int i = 1; i <= 84; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'(i);
         #1;
         chk("stream_in_ready", bus.in_ready, 1);
         chk("stream_fill_count", bus.fill_count, 32'(i - 1));
         tick();
      end
      bus.in_data = 32'hDEAD_0001;
      #1;
      chk("wait_in_ready_low", bus.in_ready, 0);
      chk("wait_fill_sat", bus.fill_count, 83);
      chk("wait_no_start", bus.start_to_next, 0);
      tick();
      chk("launch_start", bus.start_to_next, 1);
      tick();
      chk("busy_start_low", bus.start_to_next, 0);
      rd("stream_read0", 0, 1);
      rd("stream_read83", 83, 84);
      rd("stream_read42", 42, 43);

      // FC2 busy for 86 cycles while FC1 keeps offering data
      bus.end_from_next = 1'b0;
      bus.in_data       = 32'hDEAD_0002;
      for (int i = 0; i < 86; i++) begin
         tick();
         chk("hold_start", bus.start_to_next, 0);
         chk("hold_frame_done", bus.frame_done, 0);
         chk("hold_in_ready", bus.in_ready, 0);
      end
      rd("hold_read0", 0, 1);
      rd("hold_read83", 83, 84);
      bus.end_from_next = 1'b1;
      #1;
      chk("release_frame_done", bus.frame_done, 1);
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("fill_again_count", bus.fill_count, 0);
      chk("fill_again_ready", bus.in_ready, 1);
      chk("fill_again_done_low", bus.frame_done, 0);

      // fill while FC2 is still computing: launch waits
      bus.end_from_next = 1'b0;
      for (int i = 0; i < 84; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'(100 + i);
         tick();
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("stall_no_start", bus.start_to_next, 0);
         chk("stall_in_ready", bus.in_ready, 0);
      end
      bus.end_from_next = 1'b1;
      tick();
      chk("late_launch_start", bus.start_to_next, 1);
      rd("late_read5", 5, 105);
      tick();
      chk("late_busy_start", bus.start_to_next, 0);
      bus.end_from_next = 1'b0;
      tick();
      bus.end_from_next = 1'b1;
      #1;
      chk("late_frame_done", bus.frame_done, 1);
      tick();
      chk("late_fill_count", bus.fill_count, 0);

      // gapped stream: one valid in three cycles
      bus.end_from_next = 1'b0;
      for (int i = 0; i < 84; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'(200 + i);
         #1;
         chk("gap_fill_count", bus.fill_count, 32'(i));
         tick();
         bus.in_valid = 1'b0;
         tick();
         tick();
      end
      chk("gap_fill_sat", bus.fill_count, 83);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_0BAD;
      tick();
      bus.in_valid = 1'b0;
      rd("gap_read83", 83, 283);
      rd("gap_read0", 0, 200);
      rd("gap_read40", 40, 240);

      // reset while FC2 holds a full buffer
      bus.end_from_next = 1'b1;
      tick();
      chk("pre_rst_start", bus.start_to_next, 1);
      tick();
      reset = 1'b1;
      #1;
      rd("abort_read0", 0, 0);
      rd("abort_read83", 83, 0);
      rd("abort_read40", 40, 0);
      chk("abort_fill_count", bus.fill_count, 0);
      chk("abort_start", bus.start_to_next, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("abort_in_ready", bus.in_ready, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("abort_no_start", bus.start_to_next, 0);
      end
      for (int i = 0; i < 84; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'(300 + i);
         tick();
      end
      bus.in_valid = 1'b0;
      #1;
      chk("new_wait_start", bus.start_to_next, 0);
      tick();
      chk("new_launch_start", bus.start_to_next, 1);
      tick();
      bus.end_from_next = 1'b0;
      tick();
      bus.end_from_next = 1'b1;
      #1;
      chk("new_frame_done", bus.frame_done, 1);
      tick();
      chk("new_fill_count", bus.fill_count, 0);
      rd("new_read83", 83, 383);
      rd("new_read0", 0, 300);

      // indices past the buffer read as zero
      for (int i = 84; i < 128; i++) rd("oob_read", i, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
